vending_machine_change: RTL and testbench

Parametrised coin-operated vending controller that accumulates nickels, dimes and quarters toward a configurable price. It dispenses one item and then returns any overpayment as a train of nickel pulses. A cancel input refunds the accumulated credit. It is the successor to the fixed 15-cent newspaper vendor: same coin encoding, but it adds a configurable price, quarters, change return, cancel/refund, coin rejection while busy, and a sales counter.

---
 rtl/vending_machine_change.sv | 138 +++++++++++++
 tb/tb_vending_machine_change.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/vending_machine_change.sv
// Coin-operated vending controller: accumulates nickel/dime/quarter credit toward PRICE,
// vends one item, returns overpayment or refunded credit as a train of nickel pulses.
module vending_machine_change #(
  parameter int PRICE = 3,
  parameter int CW    = 4,
  parameter int SW    = 8
) (
  input  logic          clock,
  input  logic          reset,
  input  logic [1:0]    coin,
  input  logic          cancel,
  output logic          dispense,
  output logic          change_nickel,
  output logic          coin_reject,
  output logic          busy,
  output logic [CW-1:0] credit,
  output logic [SW-1:0] sales
);

  typedef enum logic [1:0] {
    ACCUM  = 2'd0,
    VEND   = 2'd1,
    CHANGE = 2'd2
  } state_t;

  localparam logic [CW:0] PRICE_W = (CW+1)'(PRICE);

  function automatic logic [2:0] coin_value(input logic [1:0] code);
    case (code)
      2'b01:   coin_value = 3'd1;
      2'b10:   coin_value = 3'd2;
      2'b11:   coin_value = 3'd5;
      default: coin_value = 3'd0;
    endcase
  endfunction

  state_t        state_r, state_s;
  logic [CW-1:0] credit_r, credit_s;
  logic [CW-1:0] change_r, change_s;
  logic [SW-1:0] sales_r, sales_s;
  logic          dispense_r, dispense_s;
  logic          change_nickel_r, change_nickel_s;
  logic          coin_reject_r, coin_reject_s;
  logic          busy_r, busy_s;
  logic [CW:0]   total_s;

  // Next-state and next-output logic; every output is the registered image of these values.
  always_comb begin
    state_s         = state_r;
    credit_s        = credit_r;
    change_s        = change_r;
    sales_s         = sales_r;
    dispense_s      = 1'b0;
    change_nickel_s = 1'b0;
    busy_s          = 1'b0;
    coin_reject_s   = (state_r != ACCUM) && (coin != 2'b00);
    total_s         = (CW+1)'(credit_r) + (CW+1)'(coin_value(coin));
    case (state_r)
      ACCUM: begin
        if (total_s >= PRICE_W) begin
          // Vending wins over a simultaneous cancel.
          state_s    = VEND;
          credit_s   = {CW{1'b0}};
          change_s   = CW'(total_s - PRICE_W);
          dispense_s = 1'b1;
          busy_s     = 1'b1;
          if (sales_r != {SW{1'b1}}) begin
            sales_s = sales_r + SW'(1);
          end else begin
            sales_s = sales_r;
          end
        end else if (cancel && (total_s != {(CW+1){1'b0}})) begin
          state_s         = CHANGE;
          change_s        = CW'(total_s);
          credit_s        = {CW{1'b0}};
          change_nickel_s = 1'b1;
          busy_s          = 1'b1;
        end else begin
          credit_s = CW'(total_s);
        end
      end
      VEND: begin
        if (change_r != {CW{1'b0}}) begin
          state_s         = CHANGE;
          change_nickel_s = 1'b1;
          busy_s          = 1'b1;
        end else begin
          state_s = ACCUM;
        end
      end
      CHANGE: begin
        // The count covers the nickel being shown now; leave as it hits zero.
        change_s = change_r - CW'(1);
        if (change_r == CW'(1)) begin
          state_s = ACCUM;
        end else begin
          change_nickel_s = 1'b1;
          busy_s          = 1'b1;
        end
      end
      default: begin
        state_s  = ACCUM;
        change_s = {CW{1'b0}};
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r         <= ACCUM;
      credit_r        <= {CW{1'b0}};
      change_r        <= {CW{1'b0}};
      sales_r         <= {SW{1'b0}};
      dispense_r      <= 1'b0;
      change_nickel_r <= 1'b0;
      coin_reject_r   <= 1'b0;
      busy_r          <= 1'b0;
    end else begin
      state_r         <= state_s;
      credit_r        <= credit_s;
      change_r        <= change_s;
      sales_r         <= sales_s;
      dispense_r      <= dispense_s;
      change_nickel_r <= change_nickel_s;
      coin_reject_r   <= coin_reject_s;
      busy_r          <= busy_s;
    end
  end

  assign dispense      = dispense_r;
  assign change_nickel = change_nickel_r;
  assign coin_reject   = coin_reject_r;
  assign busy          = busy_r;
  assign credit        = credit_r;
  assign sales         = sales_r;

endmodule

// File: tb/tb_vending_machine_change.sv
// Scoreboard bench for vending_machine_change: a behavioural model predicts each cycle's
// outputs when stimulus is driven; predictions are queued and compared after the edge.
module tb_vending_machine_change;

  localparam int PRICE = 3;
  localparam int CW    = 4;
  localparam int SW    = 8;

  logic          clock;
  logic          reset;
  logic [1:0]    coin;
  logic          cancel;
  logic          dispense;
  logic          change_nickel;
  logic          coin_reject;
  logic          busy;
  logic [CW-1:0] credit;
  logic [SW-1:0] sales;

  typedef struct packed {
    logic          disp;
    logic          chg;
    logic          rej;
    logic          busy;
    logic [CW-1:0] credit;
    logic [SW-1:0] sales;
  } exp_t;

  exp_t exp_q[$];
  exp_t m;
  int   m_owed;
  int   n_checks;
  int   n_errors;

  vending_machine_change #(.PRICE(PRICE), .CW(CW), .SW(SW)) dut (
    .clock        (clock),
    .reset        (reset),
    .coin         (coin),
    .cancel       (cancel),
    .dispense     (dispense),
    .change_nickel(change_nickel),
    .coin_reject  (coin_reject),
    .busy         (busy),
    .credit       (credit),
    .sales        (sales)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    if (obs !== expv) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, expv, $time);
    end
  endtask

  // Model: m holds the outputs of the current cycle, m_owed the nickels still to come after it.
  task automatic model_step(input logic [1:0] c, input logic can, input logic rst);
    int   v;
    int   total;
    exp_t n;
    v = (c == 2'b01) ? 1 : (c == 2'b10) ? 2 : (c == 2'b11) ? 5 : 0;
    n        = '0;
    n.credit = m.credit;
    n.sales  = m.sales;
    if (rst) begin
      n      = '0;
      m_owed = 0;
    end else if (m.busy) begin
      n.rej = (c != 2'b00);
      if (m_owed > 0) begin
        n.chg  = 1'b1;
        n.busy = 1'b1;
        m_owed = m_owed - 1;
      end
    end else begin
      total = int'(m.credit) + v;
      if (total >= PRICE) begin
        n.disp   = 1'b1;
        n.busy   = 1'b1;
        n.credit = '0;
        m_owed   = total - PRICE;
        if (m.sales != {SW{1'b1}}) n.sales = m.sales + SW'(1);
      end else if (can && total > 0) begin
        n.chg    = 1'b1;
        n.busy   = 1'b1;
        n.credit = '0;
        m_owed   = total - 1;
      end else begin
        n.credit = CW'(total);
      end
    end
    m = n;
  endtask

  task automatic cycle(input logic [1:0] c, input logic can, input logic rst);
    exp_t e;
    coin   = c;
    cancel = can;
    reset  = rst;
    model_step(c, can, rst);
    exp_q.push_back(m);
    @(posedge clock);
    #1;
    e = exp_q.pop_front();
    check("dispense", 32'(dispense), 32'(e.disp));
    check("change_nickel", 32'(change_nickel), 32'(e.chg));
    check("coin_reject", 32'(coin_reject), 32'(e.rej));
    check("busy", 32'(busy), 32'(e.busy));
    check("credit", 32'(credit), 32'(e.credit));
    check("sales", 32'(sales), 32'(e.sales));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(2'b00, 1'b0, 1'b0);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    m        = '0;
    m_owed   = 0;
    coin     = 2'b00;
    cancel   = 1'b0;
    reset    = 1'b1;

    cycle(2'b00, 1'b0, 1'b1);
    cycle(2'b00, 1'b0, 1'b1);
    idle(1);

    // three nickels with gaps
    cycle(2'b01, 1'b0, 1'b0); idle(1);
    cycle(2'b01, 1'b0, 1'b0); idle(1);
    cycle(2'b01, 1'b0, 1'b0); idle(3);

    // quarter: vend plus two nickels change
    cycle(2'b11, 1'b0, 1'b0); idle(4);

    // two dimes: one nickel change
    cycle(2'b10, 1'b0, 1'b0); idle(1);
    cycle(2'b10, 1'b0, 1'b0); idle(3);

    // nickel then dime with cancel: vend beats cancel
    cycle(2'b01, 1'b0, 1'b0); idle(1);
    cycle(2'b10, 1'b1, 1'b0); idle(3);

    // nickel then cancel alone: one nickel refund
    cycle(2'b01, 1'b0, 1'b0); idle(1);
    cycle(2'b00, 1'b1, 1'b0); idle(3);

    // cancel with nothing credited is ignored
    cycle(2'b00, 1'b1, 1'b0); idle(1);

    // dime during change train is rejected
    cycle(2'b11, 1'b0, 1'b0); idle(1);
    cycle(2'b10, 1'b0, 1'b0); idle(3);

    // back-to-back rejected coins
    cycle(2'b11, 1'b0, 1'b0);
    cycle(2'b10, 1'b0, 1'b0);
    cycle(2'b01, 1'b0, 1'b0);
    idle(3);

    // reset in first change cycle forfeits change and clears sales
    cycle(2'b11, 1'b0, 1'b0); idle(1);
    cycle(2'b00, 1'b0, 1'b1); idle(4);

    // 2^SW+1 vends: sales saturates
    for (int i = 0; i < (1 << SW) + 1; i++) begin
      cycle(2'b10, 1'b0, 1'b0);
      cycle(2'b01, 1'b0, 1'b0);
      idle(1);
    end
    idle(2);

    // random traffic, no reset
    for (int i = 0; i < 300; i++) begin
      cycle(2'($urandom_range(0, 3)), ($urandom_range(0, 7) == 0), 1'b0);
    end
    idle(8);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
